// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Byte-stream frame decoder between a UART receiver and the ACU/plank control
// logic. Frame layout: header, type, P_LEN payload bytes, channel, XOR
// checksum, footer. Good frames are committed atomically to the output
// registers. Every completed or rejected frame loads an ACK/NAK byte into a
// valid/ready response register for the feedback transmitter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | hunting for the header byte, all other bytes ignored
// S_TYPE    | expecting the type byte (low nibble must equal P_TYPE)
// S_PAYLOAD | collecting P_LEN payload bytes into the shadow buffer
// S_CHAN    | expecting the channel index (< P_NUM_CH)
// S_CHK     | expecting the XOR of header..channel
// S_FTR     | expecting the footer byte; match commits the frame
//
// Error codes: 1 type, 2 channel range, 3 checksum, 4 footer, 5 inter-byte
// timeout, 6 response overrun.
module uart_frame_decoder #(
  parameter int         P_LEN     = 17,
  parameter int         P_NUM_CH  = 8,
  parameter logic [3:0] P_TYPE    = 4'h2,
  parameter logic [7:0] P_HDR     = 8'hAA,
  parameter logic [7:0] P_FTR     = 8'h55,
  parameter logic [7:0] P_ACK     = 8'hEE,
  parameter logic [7:0] P_NAK     = 8'h11,
  parameter int         P_TIMEOUT = 100000,
  localparam int        CH_W      = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1
) (
  input  logic                 i_clk_100,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_rx_byte,
  input  logic                 i_rx_valid,
  output logic [8*P_LEN-1:0]   o_payload,
  output logic [CH_W-1:0]      o_ch_id,
  output logic [3:0]           o_type_hi,
  output logic                 o_frame_valid,
  output logic                 o_err,
  output logic [2:0]           o_err_code,
  output logic [7:0]           o_err_cnt,
  output logic [7:0]           o_resp_byte,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready
);

  localparam int               IDX_W    = (P_LEN > 1) ? $clog2(P_LEN) : 1;
  localparam int               TO_W     = $clog2(P_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(P_TIMEOUT - 1);
  localparam logic [8:0]       NUM_CH9  = 9'(P_NUM_CH);

  localparam logic [2:0] E_TYPE    = 3'd1;
  localparam logic [2:0] E_CHAN    = 3'd2;
  localparam logic [2:0] E_CHK     = 3'd3;
  localparam logic [2:0] E_FTR     = 3'd4;
  localparam logic [2:0] E_TIMEOUT = 3'd5;
  localparam logic [2:0] E_OVERRUN = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_CHAN,
    S_CHK,
    S_FTR
  } state_e;

  state_e               state_q;
  logic [7:0]           xor_q;
  logic [IDX_W-1:0]     idx_q;
  logic [8*P_LEN-1:0]   shadow_q;
  logic [CH_W-1:0]      sh_ch_q;
  logic [3:0]           sh_type_q;
  logic [TO_W-1:0]      to_cnt_q;

  logic [8*P_LEN-1:0]   payload_q;
  logic [CH_W-1:0]      ch_id_q;
  logic [3:0]           type_hi_q;
  logic                 frame_valid_q;
  logic                 err_q;
  logic [2:0]           err_code_q;
  logic [7:0]           err_cnt_q;
  logic [7:0]           resp_byte_q;
  logic                 resp_valid_q;

  logic                 timeout;
  logic                 frm_err;
  logic                 frm_ok;
  logic [2:0]           frm_code;
  logic                 resp_load;
  logic [7:0]           resp_byte_d;
  logic                 overrun;
  logic                 err_any;
  logic [2:0]           err_code_d;
  logic [1:0]           err_inc;
  logic [8:0]           cnt_sum;
  logic [7:0]           err_cnt_d;

  // Classify the current cycle: frame error, frame accepted, or timeout.
  always_comb begin
    timeout  = 1'b0;
    frm_err  = 1'b0;
    frm_ok   = 1'b0;
    frm_code = 3'd0;
    if (state_q != S_IDLE && !i_rx_valid && to_cnt_q == TO_LAST) begin
      timeout  = 1'b1;
      frm_err  = 1'b1;
      frm_code = E_TIMEOUT;
    end else if (i_rx_valid) begin
      case (state_q)
        S_TYPE: begin
          if (i_rx_byte[3:0] != P_TYPE) begin
            frm_err  = 1'b1;
            frm_code = E_TYPE;
          end
        end
        S_CHAN: begin
          if ({1'b0, i_rx_byte} >= NUM_CH9) begin
            frm_err  = 1'b1;
            frm_code = E_CHAN;
          end
        end
        S_CHK: begin
          if (i_rx_byte != xor_q) begin
            frm_err  = 1'b1;
            frm_code = E_CHK;
          end
        end
        S_FTR: begin
          if (i_rx_byte != P_FTR) begin
            frm_err  = 1'b1;
            frm_code = E_FTR;
          end else begin
            frm_ok = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response load, overrun detection and saturating error accounting.
  // When a frame error and an overrun coincide the frame cause is reported
  // on o_err_code, but both are counted.
  always_comb begin
    resp_load   = frm_ok | (frm_err & ~timeout);
    resp_byte_d = frm_ok ? P_ACK : P_NAK;
    overrun     = resp_load & resp_valid_q & ~i_resp_ready;
    err_any     = frm_err | overrun;
    err_code_d  = frm_err ? frm_code : E_OVERRUN;
    err_inc     = {1'b0, frm_err} + {1'b0, overrun};
    cnt_sum     = {1'b0, err_cnt_q} + {7'b0, err_inc};
    err_cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Frame FSM with shadow capture and atomic commit of good frames.
  always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      xor_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      sh_ch_q       <= '0;
      sh_type_q     <= '0;
      payload_q     <= '0;
      ch_id_q       <= '0;
      type_hi_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (frm_err) begin
        state_q <= S_IDLE;
      end else if (i_rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (i_rx_byte == P_HDR) begin
              xor_q   <= i_rx_byte;
              state_q <= S_TYPE;
            end
          end
          S_TYPE: begin
            sh_type_q <= i_rx_byte[7:4];
            xor_q     <= xor_q ^ i_rx_byte;
            idx_q     <= '0;
            state_q   <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            shadow_q[{idx_q, 3'b000} +: 8] <= i_rx_byte;
            xor_q <= xor_q ^ i_rx_byte;
            if (idx_q == IDX_LAST) begin
              state_q <= S_CHAN;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          S_CHAN: begin
            sh_ch_q <= i_rx_byte[CH_W-1:0];
            xor_q   <= xor_q ^ i_rx_byte;
            state_q <= S_CHK;
          end
          S_CHK: begin
            state_q <= S_FTR;
          end
          S_FTR: begin
            payload_q     <= shadow_q;
            ch_id_q       <= sh_ch_q;
            type_hi_q     <= sh_type_q;
            frame_valid_q <= 1'b1;
            state_q       <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Inter-byte timeout counter; runs only inside a frame between bytes.
  always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == S_IDLE || i_rx_valid || timeout) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Error pulse, held error code and saturating error count.
  always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q      <= 1'b0;
      err_code_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_q     <= err_any;
      err_cnt_q <= err_cnt_d;
      if (err_any) begin
        err_code_q <= err_code_d;
      end
    end
  end

  // Response register: a new load always wins over a same-cycle handshake.
  always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resp_byte_q  <= '0;
      resp_valid_q <= 1'b0;
    end else if (resp_load) begin
      resp_byte_q  <= resp_byte_d;
      resp_valid_q <= 1'b1;
    end else if (resp_valid_q && i_resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign o_payload     = payload_q;
  assign o_ch_id       = ch_id_q;
  assign o_type_hi     = type_hi_q;
  assign o_frame_valid = frame_valid_q;
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_resp_byte   = resp_byte_q;
  assign o_resp_valid  = resp_valid_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Testbench for uart_frame_decoder: scoreboard of expected frame/error
// events, popped by a monitor whenever the DUT pulses o_frame_valid/o_err.
module tb_uart_frame_decoder;

  localparam int LEN = 17;
  localparam int TO  = 300;

  logic               clk;
  logic               rst_n;
  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic [8*LEN-1:0]   payload;
  logic [2:0]         ch_id;
  logic [3:0]         type_hi;
  logic               frame_valid;
  logic               err;
  logic [2:0]         err_code;
  logic [7:0]         err_cnt;
  logic [7:0]         resp_byte;
  logic               resp_valid;
  logic               resp_ready;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic             fv;
    logic             err;
    logic [2:0]       code;
    logic [8*LEN-1:0] pl;
    logic [2:0]       ch;
    logic [3:0]       th;
    logic [7:0]       cnt;
    logic             rv;
    logic [7:0]       rb;
  } ev_t;

  ev_t              exp_q[$];
  ev_t              mon_ev;
  logic [8*LEN-1:0] last_pl;
  logic [2:0]       last_ch;
  logic [3:0]       last_th;
  logic [7:0]       exp_cnt;

  uart_frame_decoder #(.P_LEN(LEN), .P_NUM_CH(8), .P_TIMEOUT(TO)) dut (
    .i_clk_100    (clk),
    .i_rst_n      (rst_n),
    .i_rx_byte    (rx_byte),
    .i_rx_valid   (rx_valid),
    .o_payload    (payload),
    .o_ch_id      (ch_id),
    .o_type_hi    (type_hi),
    .o_frame_valid(frame_valid),
    .o_err        (err),
    .o_err_code   (err_code),
    .o_err_cnt    (err_cnt),
    .o_resp_byte  (resp_byte),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [8*LEN-1:0] fill_pl(input logic [7:0] b);
    logic [8*LEN-1:0] p;
    for (int i = 0; i < LEN; i++) p[8*i +: 8] = b;
    return p;
  endfunction

  function automatic logic [8*LEN-1:0] ramp_pl(input int seed);
    logic [8*LEN-1:0] p;
    for (int i = 0; i < LEN; i++) p[8*i +: 8] = 8'(i * 7 + seed);
    return p;
  endfunction

  function automatic logic [7:0] calc_chk(input logic [7:0] typ, input logic [8*LEN-1:0] pl,
                                          input logic [7:0] ch);
    logic [7:0] x;
    x = 8'hAA ^ typ ^ ch;
    for (int i = 0; i < LEN; i++) x ^= pl[8*i +: 8];
    return x;
  endfunction

  function automatic void push_ev(input logic fv, input logic e, input logic [2:0] code,
                                  input logic rv, input logic [7:0] rb);
    ev_t x;
    if (e) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    x.fv = fv; x.err = e; x.code = code; x.pl = last_pl; x.ch = last_ch; x.th = last_th;
    x.cnt = exp_cnt; x.rv = rv; x.rb = rb;
    exp_q.push_back(x);
  endfunction

  // Called at a negedge; the byte is sampled by the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] typ, input logic [8*LEN-1:0] pl,
                            input logic [7:0] ch, input logic [7:0] chk, input logic [7:0] ftr);
    send_byte(8'hAA);
    send_byte(typ);
    for (int i = 0; i < LEN; i++) send_byte(pl[8*i +: 8]);
    send_byte(ch);
    send_byte(chk);
    send_byte(ftr);
  endtask

  task automatic good_frame(input logic [7:0] typ, input logic [8*LEN-1:0] pl,
                            input logic [2:0] ch, input logic ovr);
    last_pl = pl; last_ch = ch; last_th = typ[7:4];
    push_ev(1'b1, ovr, 3'd6, 1'b1, 8'hEE);
    send_frame(typ, pl, {5'd0, ch}, calc_chk(typ, pl, {5'd0, ch}), 8'h55);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: fv=%0b err=%0b code=%0d, required none", frame_valid, err, err_code);
      end else begin
        n_pass++;
        mon_ev = exp_q.pop_front();
        n_checks++;
        if (frame_valid !== mon_ev.fv) $display("FAIL ev_frame_valid: got %0b want %0b", frame_valid, mon_ev.fv);
        else n_pass++;
        n_checks++;
        if (err !== mon_ev.err) $display("FAIL ev_err: got %0b want %0b", err, mon_ev.err);
        else n_pass++;
        if (mon_ev.err) begin
          n_checks++;
          if (err_code !== mon_ev.code) $display("FAIL ev_err_code: got %0d want %0d", err_code, mon_ev.code);
          else n_pass++;
        end
        n_checks++;
        if (payload !== mon_ev.pl) $display("FAIL ev_payload: got %h want %h", payload, mon_ev.pl);
        else n_pass++;
        n_checks++;
        if (ch_id !== mon_ev.ch) $display("FAIL ev_ch_id: got %0d want %0d", ch_id, mon_ev.ch);
        else n_pass++;
        n_checks++;
        if (type_hi !== mon_ev.th) $display("FAIL ev_type_hi: got %h want %h", type_hi, mon_ev.th);
        else n_pass++;
        n_checks++;
        if (err_cnt !== mon_ev.cnt) $display("FAIL ev_err_cnt: got %0d want %0d", err_cnt, mon_ev.cnt);
        else n_pass++;
        n_checks++;
        if (resp_valid !== mon_ev.rv) $display("FAIL ev_resp_valid: got %0b want %0b", resp_valid, mon_ev.rv);
        else n_pass++;
        if (mon_ev.rv) begin
          n_checks++;
          if (resp_byte !== mon_ev.rb) $display("FAIL ev_resp_byte: got %h want %h", resp_byte, mon_ev.rb);
          else n_pass++;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (payload !== '0) $display("FAIL %s_payload: got %h want 0", tag, payload); else n_pass++;
    n_checks++;
    if (ch_id !== 3'd0) $display("FAIL %s_ch_id: got %0d want 0", tag, ch_id); else n_pass++;
    n_checks++;
    if (type_hi !== 4'd0) $display("FAIL %s_type_hi: got %h want 0", tag, type_hi); else n_pass++;
    n_checks++;
    if (frame_valid !== 1'b0) $display("FAIL %s_frame_valid: got %0b want 0", tag, frame_valid); else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL %s_err: got %0b want 0", tag, err); else n_pass++;
    n_checks++;
    if (err_code !== 3'd0) $display("FAIL %s_err_code: got %0d want 0", tag, err_code); else n_pass++;
    n_checks++;
    if (err_cnt !== 8'd0) $display("FAIL %s_err_cnt: got %0d want 0", tag, err_cnt); else n_pass++;
    n_checks++;
    if (resp_byte !== 8'd0) $display("FAIL %s_resp_byte: got %h want 0", tag, resp_byte); else n_pass++;
    n_checks++;
    if (resp_valid !== 1'b0) $display("FAIL %s_resp_valid: got %0b want 0", tag, resp_valid); else n_pass++;
  endtask

  task automatic test_reset();
    check_reset_values("reset");
  endtask

  task automatic test_good_frame();
    good_frame(8'hE2, fill_pl(8'h32), 3'd0, 1'b0);
    n_checks++;
    if (payload[7:0] !== 8'h32) $display("FAIL good_byte0: got %h want 32", payload[7:0]); else n_pass++;
    n_checks++;
    if (type_hi !== 4'hE) $display("FAIL good_type_hi: got %h want e", type_hi); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (frame_valid !== 1'b0) $display("FAIL good_fv_pulse: got %0b want 0", frame_valid); else n_pass++;
    n_checks++;
    if (resp_valid !== 1'b0) $display("FAIL good_resp_handshake: got %0b want 0", resp_valid); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_checksum_error();
    push_ev(1'b0, 1'b1, 3'd3, 1'b1, 8'h11);
    send_frame(8'hE2, fill_pl(8'h32), 8'h05, 8'h00, 8'h55);
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_code !== 3'd3) $display("FAIL chk_code_held: got %0d want 3", err_code); else n_pass++;
    n_checks++;
    if (err_cnt !== 8'd1) $display("FAIL chk_err_cnt: got %0d want 1", err_cnt); else n_pass++;
  endtask

  task automatic test_type_and_footer_errors();
    push_ev(1'b0, 1'b1, 3'd1, 1'b1, 8'h11);
    send_byte(8'hAA);
    send_byte(8'hE3);
    for (int i = 0; i < 4; i++) send_byte(8'h32);
    repeat (2) @(negedge clk);
    push_ev(1'b0, 1'b1, 3'd4, 1'b1, 8'h11);
    send_frame(8'h72, ramp_pl(9), 8'h04, calc_chk(8'h72, ramp_pl(9), 8'h04), 8'h56);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_chan_range();
    push_ev(1'b0, 1'b1, 3'd2, 1'b1, 8'h11);
    send_byte(8'hAA);
    send_byte(8'hE2);
    for (int i = 0; i < LEN; i++) send_byte(8'h32);
    send_byte(8'h08);
    send_byte(8'h7A);
    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (2) @(negedge clk);
    good_frame(8'h92, ramp_pl(3), 3'd7, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ch_id !== 3'd7) $display("FAIL chan_max: got %0d want 7", ch_id); else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    seen = 1'b0;
    push_ev(1'b0, 1'b1, 3'd5, 1'b0, 8'h00);
    send_byte(8'hAA);
    send_byte(8'hE2);
    for (int i = 0; i < 5; i++) send_byte(8'h32);
    n = 0;
    for (int k = 1; k <= TO + 20; k++) begin
      @(negedge clk);
      if (err) begin
        n = k;
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL timeout_seen: no error within %0d cycles, want after %0d", TO + 20, TO);
    else if (n !== TO) $display("FAIL timeout_latency: got %0d cycles want %0d", n, TO);
    else n_pass++;
    repeat (2) @(negedge clk);
    good_frame(8'h12, ramp_pl(40), 3'd2, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    good_frame(8'hE2, fill_pl(8'h01), 3'd1, 1'b0);
    repeat (2) @(negedge clk);
    good_frame(8'hE2, fill_pl(8'h02), 3'd2, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1) $display("FAIL bp_pending: got %0b want 1", resp_valid); else n_pass++;
    n_checks++;
    if (resp_byte !== 8'hEE) $display("FAIL bp_byte: got %h want ee", resp_byte); else n_pass++;
    n_checks++;
    if (err_code !== 3'd6) $display("FAIL bp_code: got %0d want 6", err_code); else n_pass++;
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) $display("FAIL bp_release: got %0b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    good_frame(8'h32, ramp_pl(5), 3'd3, 1'b0);
    good_frame(8'hA2, ramp_pl(77), 3'd6, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hAA);
    send_byte(8'hE2);
    for (int i = 0; i < 4; i++) send_byte(8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    exp_cnt = 8'd0;
    last_pl = '0;
    last_ch = 3'd0;
    last_th = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    good_frame(8'h52, ramp_pl(11), 3'd4, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_byte    = 8'h00;
    rx_valid   = 1'b0;
    resp_ready = 1'b1;
    exp_cnt    = 8'd0;
    last_pl    = '0;
    last_ch    = 3'd0;
    last_th    = 4'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_good_frame();
    test_checksum_error();
    test_type_and_footer_errors();
    test_chan_range();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL missing_events: %0d expected events never seen, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Parametrised byte-stream frame decoder that sits between a UART receiver and the ACU/plank control logic. It replaces the fixed-length, fixed-channel frame checks with one configurable engine: header, type nibble, N-byte payload, channel index, XOR checksum and footer. Good frames are committed atomically to a payload register. Every completed or rejected frame produces an ACK/NAK response byte for the feedback UART transmitter through a valid/ready handshake.

## Interface
- P_LEN, 17: payload bytes per frame (1..64)
- P_NUM_CH, 8: number of addressable channels; channel byte must be < P_NUM_CH
- P_TYPE, 4'h2: required low nibble of the type byte
- P_HDR, 8'hAA: header byte
- P_FTR, 8'h55: footer byte
- P_ACK, 8'hEE: response byte for a good frame
- P_NAK, 8'h11: response byte for a rejected frame
- P_TIMEOUT, 100000: maximum idle clocks between bytes inside a frame (≈1 ms at 100 MHz)

Ports:
- i_clk_100  in  1  system clock, 100 MHz; sole clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_rx_byte  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_byte valid
- o_payload  out  8*P_LEN  last good payload; byte 0 in bits [7:0]
- o_ch_id  out  clog2(P_NUM_CH)  channel of last good frame
- o_type_hi  out  4  high nibble of last good type byte
- o_frame_valid  out  1  one-cycle pulse: good frame committed
- o_err  out  1  one-cycle pulse: frame rejected
- o_err_code  out  3  cause, valid with o_err and held until the next error
- o_err_cnt  out  8  saturating count of rejected frames
- o_resp_byte  out  8  ACK/NAK byte to feedback transmitter
- o_resp_valid  out  1  response pending
- i_resp_ready  in  1  transmitter accepts response

## Operation
- States: IDLE, TYPE, PAYLOAD, CHAN, CHK, FTR.
- Only cycles with i_rx_valid=1 advance the FSM.
- IDLE: a byte equal to P_HDR clears the running XOR, XORs in the header, and moves to TYPE. Any other byte is ignored, with no error.
- TYPE: low nibble ≠ P_TYPE → error 1. Otherwise store the high nibble and go to PAYLOAD with the byte counter at 0.
- PAYLOAD: write each byte to the shadow buffer at the counter index. Counter = P_LEN-1 → CHAN.
- CHAN: value ≥ P_NUM_CH → error 2. Otherwise store it and go to CHK.
- CHK: byte ≠ running XOR of header..channel → error 3. Otherwise go to FTR.
- FTR: byte ≠ P_FTR → error 4. Otherwise:
  - commit shadow payload, channel and type to the outputs;
  - pulse o_frame_valid;
  - load P_ACK into the response;
  - return to IDLE.
- Timeout: outside IDLE, P_TIMEOUT consecutive cycles without i_rx_valid → error 5, return to IDLE. The timeout produces no response byte.
- Any error:
  - return to IDLE;
  - pulse o_err and set o_err_code;
  - increment o_err_cnt, saturating at 255;
  - for codes 1–4, load P_NAK into the response.
- A rejected frame never changes o_payload, o_ch_id or o_type_hi.
- Response register:
  - o_resp_valid is set on load and cleared when o_resp_valid & i_resp_ready.
  - A new load while a response is pending overwrites o_resp_byte; o_resp_valid stays high and error code 6 is reported (overrun pulse on o_err, counted).
  - If a load coincides with a handshake, the new response wins and stays valid.

## Timing
- Reset values:
  - FSM IDLE;
  - o_payload = 0, o_ch_id = 0, o_type_hi = 0;
  - o_frame_valid = 0, o_err = 0, o_err_code = 0, o_err_cnt = 0;
  - o_resp_byte = 0, o_resp_valid = 0;
  - timeout counter = 0.
- o_frame_valid, the committed outputs and o_resp_valid all change on the clock edge after the cycle in which the footer byte is valid.
- o_err fires on the edge after the offending byte, or after the P_TIMEOUT-th idle cycle.
- The timeout counter resets on every i_rx_valid and is held at 0 in IDLE.
- A header byte arriving in the cycle an error returns the FSM to IDLE is discarded; decoding resumes with the next header.
- Reset mid-frame discards the shadow buffer and any pending response immediately.
- Back-to-back frames with no gap are supported: the FSM is in IDLE on the cycle after the footer.

## Test plan
- Good frame: AA, E2, 17×32, 00, 7A, 55 → one o_frame_valid pulse; every o_payload byte = 32, o_ch_id = 0, o_type_hi = E; o_resp_byte = EE.
- Checksum error: same frame on channel 05 with checksum 00 (correct value 7F) → o_err with code 3, o_resp_byte = 11; o_payload unchanged; o_err_cnt = 1.
- Channel out of range (byte 08, P_NUM_CH = 8) → code 2 at the channel byte; the following bytes are ignored until the next AA.
- Timeout: stop after 5 payload bytes → code 5 exactly P_TIMEOUT cycles after the last byte; no response; the next good frame decodes normally.
- Response backpressure: hold i_resp_ready = 0 across two good frames → code 6 and o_resp_byte = EE still pending. Then raise i_resp_ready for one cycle → o_resp_valid clears.
- Reset assertion during PAYLOAD → all outputs return to reset values within the same cycle; the next full frame decodes correctly.
